// File: rtl/mem_pkg.sv
// Shared constants for the load/store memory stage: funct3 codes and FSM state encoding.
package mem_pkg;

    // Load funct3 codes
    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    // Store funct3 codes
    localparam logic [2:0] ST_SB  = 3'b000;
    localparam logic [2:0] ST_SH  = 3'b001;
    localparam logic [2:0] ST_SW  = 3'b010;

    // FSM state encoding
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_READ = 1'b1;

endpackage

// File: rtl/dmem_ram.sv
// Synchronous single-port data RAM with byte enables and write-first read behaviour.
// Only the read register is reset; the array keeps its contents across reset.
module dmem_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          re,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    // Read data: hold unless reading; enabled lanes being written return the new bytes
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            for (int i = 0; i < 4; i++) begin
                rdata_d[8*i +: 8] = we[i] ? wdata[8*i +: 8] : mem[addr][8*i +: 8];
            end
        end
    end

    // Byte-lane writes into the array (no reset on storage)
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Read output register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: decodes loads/stores, traps misaligned or unsupported
// accesses, drives the data RAM and extracts/extends load results.
//
// state  | meaning
// IDLE   | accepting requests; a legal load raises mem_busy and issues the RAM read
// READ   | RAM word captured; data_valid=1, requests ignored, back to IDLE next edge
module mem_stage
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read_en,
    input  logic        mem_write_en,
    input  logic [2:0]  load_type,
    input  logic [2:0]  store_type,
    input  logic [31:0] ram_address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        data_valid,
    output logic        mem_busy,
    output logic        misaligned
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [0:0]    state_q, state_d;
    logic [2:0]    ld_type_q, ld_type_d;
    logic [1:0]    lane_q, lane_d;

    logic          in_idle, read_req, write_req;
    logic          ld_mis, st_mis;
    logic [3:0]    st_be, ram_we;
    logic [31:0]   ram_wdata, ram_rdata;
    logic [AW-1:0] ram_index;
    logic          unused_addr_hi;

    // Upper address bits are ignored so the address wraps over the RAM size
    assign ram_index      = ram_address[AW+1:2];
    assign unused_addr_hi = ^ram_address[31:AW+2];

    // Access decode: alignment checks, byte enables and lane-replicated store data
    always_comb begin
        ld_mis    = 1'b0;
        st_mis    = 1'b0;
        st_be     = 4'b0000;
        ram_wdata = data_in;
        case (load_type)
            LD_LB, LD_LBU: ld_mis = 1'b0;
            LD_LH, LD_LHU: ld_mis = ram_address[0];
            LD_LW:         ld_mis = |ram_address[1:0];
            default:       ld_mis = 1'b1;
        endcase
        case (store_type)
            ST_SB: begin
                st_be     = 4'b0001 << ram_address[1:0];
                ram_wdata = {4{data_in[7:0]}};
            end
            ST_SH: begin
                st_mis    = ram_address[0];
                st_be     = ram_address[1] ? 4'b1100 : 4'b0011;
                ram_wdata = {2{data_in[15:0]}};
            end
            ST_SW: begin
                st_mis    = |ram_address[1:0];
                st_be     = 4'b1111;
            end
            default: st_mis = 1'b1;
        endcase
    end

    // Request qualification; a store wins when both enables are high
    always_comb begin
        in_idle    = (state_q == S_IDLE);
        write_req  = in_idle & mem_write_en;
        read_req   = in_idle & mem_read_en & ~mem_write_en;
        misaligned = (write_req & st_mis) | (read_req & ld_mis);
        mem_busy   = read_req & ~ld_mis;
        ram_we     = (write_req & ~st_mis) ? st_be : 4'b0000;
        data_valid = (state_q == S_READ);
    end

    // Next-state logic; load type and lane are captured alongside the RAM read
    always_comb begin
        state_d   = state_q;
        ld_type_d = ld_type_q;
        lane_d    = lane_q;
        if (state_q == S_READ) begin
            state_d = S_IDLE;
        end else if (mem_busy) begin
            state_d   = S_READ;
            ld_type_d = load_type;
            lane_d    = ram_address[1:0];
        end
    end

    // State and load-context registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ld_type_q <= LD_LW;
            lane_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            ld_type_q <= ld_type_d;
            lane_q    <= lane_d;
        end
    end

    // Lane select and extension of the registered RAM word. Every input here is a
    // flop, and the RAM register only changes on a load, so data_out holds between loads.
    always_comb begin
        logic [31:0] shifted;
        logic [15:0] half;
        shifted = ram_rdata >> {lane_q, 3'b000};
        half    = lane_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        case (ld_type_q)
            LD_LB:   data_out = {{24{shifted[7]}}, shifted[7:0]};
            LD_LBU:  data_out = {24'h0, shifted[7:0]};
            LD_LH:   data_out = {{16{half[15]}}, half};
            LD_LHU:  data_out = {16'h0, half};
            default: data_out = ram_rdata;
        endcase
    end

    dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_dmem_ram (
        .clk   (clk),
        .reset (reset),
        .re    (mem_busy),
        .we    (ram_we),
        .addr  (ram_index),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stores, loads, extension, traps, reset and wrap.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [2:0]  load_type;
    logic [2:0]  store_type;
    logic [31:0] ram_address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        data_valid;
    logic        mem_busy;
    logic        misaligned;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_stage #(.DEPTH_WORDS(1024)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .load_type    (load_type),
        .store_type   (store_type),
        .ram_address  (ram_address),
        .data_in      (data_in),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .mem_busy     (mem_busy),
        .misaligned   (misaligned)
    );

    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic drive_idle();
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        load_type    = 3'b010;
        store_type   = 3'b010;
        ram_address  = 32'h0;
        data_in      = 32'h0;
    endtask

    // Called at a negedge in IDLE; returns at the following negedge
    task automatic do_store(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
        mem_write_en = 1'b1;
        mem_read_en  = 1'b0;
        store_type   = t;
        ram_address  = a;
        data_in      = d;
        @(posedge clk);
        @(negedge clk);
        drive_idle();
    endtask

    // Called at a negedge in IDLE; samples in READ, returns at a negedge back in IDLE
    task automatic do_load(input logic [2:0] t, input logic [31:0] a,
                           output logic [31:0] v, output logic vld);
        mem_read_en = 1'b1;
        load_type   = t;
        ram_address = a;
        @(posedge clk);
        @(negedge clk);
        v   = data_out;
        vld = data_valid;
        drive_idle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_idle();
        @(negedge clk);
        total++; if (data_out !== 32'h0) begin bad++; $display("FAIL reset_data_out got=%h exp=%h", data_out, 32'h0); end
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", data_valid); end
        total++; if (mem_busy !== 1'b0) begin bad++; $display("FAIL reset_busy_idle got=%b exp=0", mem_busy); end
        mem_read_en = 1'b1; load_type = 3'b010; ram_address = 32'h10;
        #1;
        total++; if (mem_busy !== 1'b1) begin bad++; $display("FAIL reset_busy_follows got=%b exp=1", mem_busy); end
        load_type = 3'b001; ram_address = 32'h3;
        #1;
        total++; if (misaligned !== 1'b1) begin bad++; $display("FAIL reset_mis_follows got=%b exp=1", misaligned); end
        drive_idle();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_word();
        do_store(3'b010, 32'h10, 32'hDEADBEEF);
        mem_read_en = 1'b1; load_type = 3'b010; ram_address = 32'h10;
        #1;
        total++; if (mem_busy !== 1'b1) begin bad++; $display("FAIL lw_busy got=%b exp=1", mem_busy); end
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL lw_valid_early got=%b exp=0", data_valid); end
        @(posedge clk);
        @(negedge clk);
        total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL lw_valid got=%b exp=1", data_valid); end
        total++; if (mem_busy !== 1'b0) begin bad++; $display("FAIL lw_busy_read got=%b exp=0", mem_busy); end
        total++; if (data_out !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data got=%h exp=%h", data_out, 32'hDEADBEEF); end
        drive_idle();
        @(posedge clk);
        @(negedge clk);
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL lw_valid_drop got=%b exp=0", data_valid); end
        total++; if (data_out !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_hold got=%h exp=%h", data_out, 32'hDEADBEEF); end
    endtask

    task automatic test_byte_half();
        logic [31:0] v;
        logic        vld;
        do_store(3'b010, 32'h20, 32'h11223344);
        do_store(3'b000, 32'h21, 32'hABCDEF80);
        do_load(3'b000, 32'h21, v, vld);
        total++; if (v !== 32'hFFFFFF80) begin bad++; $display("FAIL lb got=%h exp=%h", v, 32'hFFFFFF80); end
        total++; if (vld !== 1'b1) begin bad++; $display("FAIL lb_valid got=%b exp=1", vld); end
        do_load(3'b100, 32'h21, v, vld);
        total++; if (v !== 32'h00000080) begin bad++; $display("FAIL lbu got=%h exp=%h", v, 32'h00000080); end
        do_load(3'b010, 32'h20, v, vld);
        total++; if (v !== 32'h11228044) begin bad++; $display("FAIL sb_lanes got=%h exp=%h", v, 32'h11228044); end
        do_load(3'b001, 32'h20, v, vld);
        total++; if (v !== 32'hFFFF8044) begin bad++; $display("FAIL lh got=%h exp=%h", v, 32'hFFFF8044); end
        do_load(3'b101, 32'h22, v, vld);
        total++; if (v !== 32'h00001122) begin bad++; $display("FAIL lhu_hi got=%h exp=%h", v, 32'h00001122); end
        do_store(3'b001, 32'h22, 32'h1234BEEF);
        do_load(3'b001, 32'h22, v, vld);
        total++; if (v !== 32'hFFFFBEEF) begin bad++; $display("FAIL sh_lh got=%h exp=%h", v, 32'hFFFFBEEF); end
        do_load(3'b010, 32'h20, v, vld);
        total++; if (v !== 32'hBEEF8044) begin bad++; $display("FAIL sh_lanes got=%h exp=%h", v, 32'hBEEF8044); end
        do_load(3'b000, 32'h23, v, vld);
        total++; if (v !== 32'hFFFFFFBE) begin bad++; $display("FAIL lb_lane3 got=%h exp=%h", v, 32'hFFFFFFBE); end
    endtask

    task automatic test_misaligned();
        logic [31:0] v;
        logic        vld;
        do_store(3'b010, 32'h04, 32'h01020304);
        do_load(3'b010, 32'h04, v, vld);
        total++; if (v !== 32'h01020304) begin bad++; $display("FAIL mis_setup got=%h exp=%h", v, 32'h01020304); end
        mem_read_en = 1'b1; load_type = 3'b001; ram_address = 32'h03;
        #1;
        total++; if (misaligned !== 1'b1) begin bad++; $display("FAIL lh_mis got=%b exp=1", misaligned); end
        total++; if (mem_busy !== 1'b0) begin bad++; $display("FAIL lh_mis_busy got=%b exp=0", mem_busy); end
        @(posedge clk);
        @(negedge clk);
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL lh_mis_valid got=%b exp=0", data_valid); end
        total++; if (data_out !== 32'h01020304) begin bad++; $display("FAIL lh_mis_hold got=%h exp=%h", data_out, 32'h01020304); end
        drive_idle();
        mem_write_en = 1'b1; store_type = 3'b010; ram_address = 32'h06; data_in = 32'hFFFFFFFF;
        #1;
        total++; if (misaligned !== 1'b1) begin bad++; $display("FAIL sw_mis got=%b exp=1", misaligned); end
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        mem_write_en = 1'b1; store_type = 3'b001; ram_address = 32'h05; data_in = 32'hFFFFFFFF;
        #1;
        total++; if (misaligned !== 1'b1) begin bad++; $display("FAIL sh_mis got=%b exp=1", misaligned); end
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        mem_write_en = 1'b1; store_type = 3'b011; ram_address = 32'h04; data_in = 32'hFFFFFFFF;
        #1;
        total++; if (misaligned !== 1'b1) begin bad++; $display("FAIL st_unsup got=%b exp=1", misaligned); end
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        mem_read_en = 1'b1; load_type = 3'b011; ram_address = 32'h04;
        #1;
        total++; if (misaligned !== 1'b1) begin bad++; $display("FAIL ld_unsup got=%b exp=1", misaligned); end
        total++; if (mem_busy !== 1'b0) begin bad++; $display("FAIL ld_unsup_busy got=%b exp=0", mem_busy); end
        @(posedge clk);
        @(negedge clk);
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL ld_unsup_valid got=%b exp=0", data_valid); end
        drive_idle();
        do_load(3'b010, 32'h04, v, vld);
        total++; if (v !== 32'h01020304) begin bad++; $display("FAIL mis_ram_kept got=%h exp=%h", v, 32'h01020304); end
    endtask

    task automatic test_both_enables();
        logic [31:0] v;
        logic        vld;
        mem_read_en = 1'b1; mem_write_en = 1'b1;
        load_type = 3'b010; store_type = 3'b010;
        ram_address = 32'h40; data_in = 32'h12345678;
        #1;
        total++; if (mem_busy !== 1'b0) begin bad++; $display("FAIL both_busy got=%b exp=0", mem_busy); end
        total++; if (misaligned !== 1'b0) begin bad++; $display("FAIL both_mis got=%b exp=0", misaligned); end
        @(posedge clk);
        @(negedge clk);
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL both_valid got=%b exp=0", data_valid); end
        drive_idle();
        do_load(3'b010, 32'h40, v, vld);
        total++; if (v !== 32'h12345678) begin bad++; $display("FAIL both_write got=%h exp=%h", v, 32'h12345678); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        logic        vld;
        do_store(3'b010, 32'h50, 32'hCAFEF00D);
        do_load(3'b010, 32'h50, v, vld);
        total++; if (v !== 32'hCAFEF00D) begin bad++; $display("FAIL write_first got=%h exp=%h", v, 32'hCAFEF00D); end
        do_store(3'b010, 32'h60, 32'h0BADF00D);
        mem_read_en = 1'b1; load_type = 3'b010; ram_address = 32'h60;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (mem_busy !== (i % 2 == 0)) begin bad++; $display("FAIL b2b_busy[%0d] got=%b exp=%b", i, mem_busy, (i % 2 == 0)); end
            total++; if (data_valid !== (i % 2 == 1)) begin bad++; $display("FAIL b2b_valid[%0d] got=%b exp=%b", i, data_valid, (i % 2 == 1)); end
            @(posedge clk);
            @(negedge clk);
        end
        total++; if (data_out !== 32'h0BADF00D) begin bad++; $display("FAIL b2b_data got=%h exp=%h", data_out, 32'h0BADF00D); end
        @(posedge clk);
        @(negedge clk);
        // now in READ: a store offered here must be ignored
        mem_read_en = 1'b0; mem_write_en = 1'b1; store_type = 3'b010; data_in = 32'hFFFF0000;
        #1;
        total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL in_read_state got=%b exp=1", data_valid); end
        total++; if (mem_busy !== 1'b0) begin bad++; $display("FAIL in_read_busy got=%b exp=0", mem_busy); end
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        do_load(3'b010, 32'h60, v, vld);
        total++; if (v !== 32'h0BADF00D) begin bad++; $display("FAIL read_ignores_write got=%h exp=%h", v, 32'h0BADF00D); end
    endtask

    task automatic test_reset_in_read();
        logic [31:0] v;
        logic        vld;
        mem_read_en = 1'b1; load_type = 3'b010; ram_address = 32'h40;
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive_idle();
        @(negedge clk);
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL rst_read_valid got=%b exp=0", data_valid); end
        total++; if (data_out !== 32'h0) begin bad++; $display("FAIL rst_read_data got=%h exp=%h", data_out, 32'h0); end
        reset = 1'b0;
        @(negedge clk);
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL rst_read_after got=%b exp=0", data_valid); end
        do_load(3'b010, 32'h40, v, vld);
        total++; if (v !== 32'h12345678) begin bad++; $display("FAIL rst_ram_kept got=%h exp=%h", v, 32'h12345678); end
    endtask

    task automatic test_wrap();
        logic [31:0] v;
        logic        vld;
        do_store(3'b010, 32'h00001008, 32'hA5A5A5A5);
        do_load(3'b010, 32'h00000008, v, vld);
        total++; if (v !== 32'hA5A5A5A5) begin bad++; $display("FAIL wrap got=%h exp=%h", v, 32'hA5A5A5A5); end
        do_load(3'b010, 32'hF0000008, v, vld);
        total++; if (v !== 32'hA5A5A5A5) begin bad++; $display("FAIL wrap_hi got=%h exp=%h", v, 32'hA5A5A5A5); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_half();
        test_misaligned();
        test_both_enables();
        test_back_to_back();
        test_reset_in_read();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
